reg_bus_fabric: RTL and testbench

- Parametrised register-space interconnect between the CPU bus and up to 15 peripheral wrappers (uart, timers, gpio, ...).
- Replaces the fixed single-uart decode in the SoC top.
- Decodes the register page into 16-byte slots and muxes read data and wait.
- Adds a per-access wait timeout, unmapped-access detection, a sticky fault-capture status block and an error interrupt.

---
 rtl/soc_regmap_pkg.sv | 32 +++
 rtl/reg_bus_timeout.sv | 67 ++++++
 rtl/reg_bus_fabric.sv | 134 +++++++++++++
 tb/tb_reg_bus_fabric.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_regmap_pkg.sv
// Purpose : shared constants, status-block layout and timeout FSM states for the register-space fabric.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package soc_regmap_pkg;

   // Each peripheral slot decodes 16 bytes; address bits [3:0] go to the slot.
   localparam int SLOT_W = 4;

   // Slot index 15 always holds the fabric's own status block.
   localparam logic [3:0] STATUS_SLOT = 4'hF;

   // Status block register offsets.
   localparam logic [3:0] OFF_STATUS     = 4'h0;
   localparam logic [3:0] OFF_FAULT_ADDR = 4'h1;
   localparam logic [3:0] OFF_FAULT_INFO = 4'h2;
   localparam logic [3:0] OFF_CTRL       = 4'h3;

   // STATUS bit positions.
   localparam int ST_TIMEOUT_BIT  = 0;
   localparam int ST_UNMAPPED_BIT = 1;

   // Wait-timeout FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } tmo_state_t;

   // Read data returned for unmapped and aborted accesses.
   localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/reg_bus_timeout.sv
// Purpose : counts consecutive stall cycles of one slot access and forces a one-cycle abort at TIMEOUT.
// Latency : abort is asserted the cycle after the TIMEOUT-th stalled cycle, for exactly one cycle.
// Backpressure: none of its own; it only bounds the stall the selected slot applies.
// Ports: clk, rst (sync, active-high); access = strobe to a peripheral slot; stall = that slot's wait;
//        abort = ABORT state (strobes/wait masked by the top); timeout_event = set pulse for STATUS.timeout.
module reg_bus_timeout
   import soc_regmap_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic access,
   input  logic stall,
   output logic abort,
   output logic timeout_event
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   tmo_state_t       state;
   logic [CNT_W-1:0] cnt;

   // cnt holds the number of stalled cycles already seen. The IDLE cycle that
   // starts a stalled access is the first one, so the move to ABORT happens on
   // the edge that would bring cnt to TIMEOUT: the CPU sees exactly TIMEOUT
   // stall cycles before the abort cycle. The >= compare also keeps cnt from
   // ever passing TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (access && stall) begin
                  state <= ST_BUSY;
                  cnt   <= CNT_W'(1);
               end
            end
            ST_BUSY: begin
               if (!access || !stall) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
                  state <= ST_ABORT;
                  cnt   <= CNT_W'(TIMEOUT);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_ABORT: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign abort         = (state == ST_ABORT);
   assign timeout_event = (state == ST_ABORT);

endmodule

// File: rtl/reg_bus_fabric.sv
// Purpose : decodes the CPU register page into 16-byte slots, muxes slot data/wait, adds timeout, unmapped detect, fault status and error irq.
// Latency : slot strobes, read data and wait are combinational; status flags update on the access edge; irq_error one cycle after STATUS/CTRL.
// Backpressure: bus_wait follows the selected slot's wait, capped at TIMEOUT cycles; status and unmapped accesses never stall.
// Ports: clk, rst (sync, active-high); CPU side bus_address/bus_data_tx/bus_read/bus_write -> bus_data_rx/bus_wait/bus_hit;
//        slot side slot_address/slot_data_tx/slot_read/slot_write -> slot_data_rx/slot_wait; irq_error.
module reg_bus_fabric
   import soc_regmap_pkg::*;
#(
   parameter int         NUM_SLOTS = 4,
   parameter int         TIMEOUT   = 255,
   parameter logic [7:0] BASE_PAGE = 8'hFF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            bus_address,
   input  logic [7:0]             bus_data_tx,
   output logic [7:0]             bus_data_rx,
   input  logic                   bus_read,
   input  logic                   bus_write,
   output logic                   bus_wait,
   output logic                   bus_hit,
   output logic [SLOT_W-1:0]      slot_address,
   output logic [7:0]             slot_data_tx,
   output logic [NUM_SLOTS-1:0]   slot_read,
   output logic [NUM_SLOTS-1:0]   slot_write,
   input  logic [8*NUM_SLOTS-1:0] slot_data_rx,
   input  logic [NUM_SLOTS-1:0]   slot_wait,
   output logic                   irq_error
);

   logic [3:0] idx;
   logic [3:0] off;
   logic       sel_slot, sel_status, sel_unmapped;
   logic       slot_access, slot_stall, abort, timeout_event, unmapped_event;
   logic [7:0] slot_rdat, status_rdat;
   logic [1:0] status_set, status_clr;

   logic [1:0] status;
   logic [7:0] fault_addr;
   logic       fault_write;
   logic       irq_enable;

   assign idx          = bus_address[7:4];
   assign off          = bus_address[3:0];
   assign bus_hit      = (bus_address[15:8] == BASE_PAGE);
   assign slot_address = bus_address[3:0];
   assign slot_data_tx = bus_data_tx;

   assign sel_slot     = bus_hit && (int'(idx) < NUM_SLOTS);
   assign sel_status   = bus_hit && (idx == STATUS_SLOT);
   assign sel_unmapped = bus_hit && !sel_slot && !sel_status;

   // Slot select: data/wait mux and one-hot strobes. Strobes are masked during
   // the abort cycle so the stuck slot never sees the discarded access complete.
   always_comb begin
      slot_rdat  = '0;
      slot_stall = 1'b0;
      slot_read  = '0;
      slot_write = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (idx == 4'(k)) begin
            slot_rdat     = slot_data_rx[8*k +: 8];
            slot_stall    = slot_wait[k];
            slot_read[k]  = bus_read && sel_slot && !abort;
            slot_write[k] = bus_write && sel_slot && !abort;
         end
      end
   end

   assign slot_access    = sel_slot && (bus_read || bus_write);
   assign unmapped_event = sel_unmapped && (bus_read || bus_write);
   assign bus_wait       = sel_slot && slot_stall && !abort;

   reg_bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk           (clk),
      .rst           (rst),
      .access        (slot_access),
      .stall         (slot_stall),
      .abort         (abort),
      .timeout_event (timeout_event)
   );

   // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
   always_comb begin
      status_set                  = 2'b00;
      status_set[ST_TIMEOUT_BIT]  = timeout_event;
      status_set[ST_UNMAPPED_BIT] = unmapped_event;
      status_clr                  = 2'b00;
      if (sel_status && bus_write && off == OFF_STATUS) begin
         status_clr = bus_data_tx[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status      <= 2'b00;
         fault_addr  <= 8'h00;
         fault_write <= 1'b0;
         irq_enable  <= 1'b0;
         irq_error   <= 1'b0;
      end else begin
         status <= (status & ~status_clr) | status_set;
         // Only the first fault after STATUS was cleared is captured.
         if (status == 2'b00 && status_set != 2'b00) begin
            fault_addr  <= bus_address[7:0];
            fault_write <= bus_write;
         end
         if (sel_status && bus_write && off == OFF_CTRL) begin
            irq_enable <= bus_data_tx[0];
         end
         irq_error <= irq_enable && (status != 2'b00);
      end
   end

   always_comb begin
      case (off)
         OFF_STATUS:     status_rdat = {6'b0, status};
         OFF_FAULT_ADDR: status_rdat = fault_addr;
         OFF_FAULT_INFO: status_rdat = {7'b0, fault_write};
         OFF_CTRL:       status_rdat = {7'b0, irq_enable};
         default:        status_rdat = 8'h00;
      endcase
   end

   always_comb begin
      if (abort)           bus_data_rx = UNMAPPED_DATA;
      else if (sel_slot)   bus_data_rx = slot_rdat;
      else if (sel_status) bus_data_rx = status_rdat;
      else                 bus_data_rx = UNMAPPED_DATA;
   end

endmodule

// File: tb/tb_reg_bus_fabric.sv
// Purpose : directed self-checking bench for reg_bus_fabric (NUM_SLOTS=4, TIMEOUT=8).
// Latency : inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: slot waits driven directly; every wait loop is cycle-bounded.
module tb_reg_bus_fabric;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic [15:0] bus_address;
   logic [7:0]  bus_data_tx;
   logic [7:0]  bus_data_rx;
   logic        bus_read;
   logic        bus_write;
   logic        bus_wait;
   logic        bus_hit;
   logic [3:0]  slot_address;
   logic [7:0]  slot_data_tx;
   logic [3:0]  slot_read;
   logic [3:0]  slot_write;
   logic [31:0] slot_data_rx;
   logic [3:0]  slot_wait;
   logic        irq_error;

   int          n_chk;
   int          n_err;
   logic [7:0]  rdat;

   reg_bus_fabric #(
      .NUM_SLOTS (4),
      .TIMEOUT   (TMO),
      .BASE_PAGE (8'hFF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus_address  (bus_address),
      .bus_data_tx  (bus_data_tx),
      .bus_data_rx  (bus_data_rx),
      .bus_read     (bus_read),
      .bus_write    (bus_write),
      .bus_wait     (bus_wait),
      .bus_hit      (bus_hit),
      .slot_address (slot_address),
      .slot_data_tx (slot_data_tx),
      .slot_read    (slot_read),
      .slot_write   (slot_write),
      .slot_data_rx (slot_data_rx),
      .slot_wait    (slot_wait),
      .irq_error    (irq_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_read    = 1'b0;
      bus_write   = 1'b0;
      bus_address = 16'h0000;
   endtask

   // One zero-wait read; returns the data seen in the access cycle.
   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      nxt();
      bus_address = a;
      bus_read    = 1'b1;
      bus_write   = 1'b0;
      #1 d = bus_data_rx;
      nxt();
      idle();
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      nxt();
      bus_address = a;
      bus_data_tx = d;
      bus_write   = 1'b1;
      bus_read    = 1'b0;
      nxt();
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (3) nxt();
      #1;
      n_chk++; if (irq_error !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq_error); end
      n_chk++; if (bus_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b expected 0", bus_hit); end
      n_chk++; if (slot_read !== 4'b0000) begin n_err++; $display("FAIL reset_slot_read: got %b expected 0000", slot_read); end
      rst = 1'b0;
      rd(16'hFFF0, rdat);
      n_chk++; if (rdat !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h expected 00", rdat); end
      rd(16'hFFF1, rdat);
      n_chk++; if (rdat !== 8'h00) begin n_err++; $display("FAIL reset_fault_addr: got %h expected 00", rdat); end
      rd(16'hFFF3, rdat);
      n_chk++; if (rdat !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00", rdat); end
   endtask

   task automatic test_slot_read();
      nxt();
      bus_address = 16'hFF03;
      bus_read    = 1'b1;
      #1;
      n_chk++; if (slot_read !== 4'b0001) begin n_err++; $display("FAIL rd0_strobe: got %b expected 0001", slot_read); end
      n_chk++; if (slot_write !== 4'b0000) begin n_err++; $display("FAIL rd0_wstrobe: got %b expected 0000", slot_write); end
      n_chk++; if (slot_address !== 4'h3) begin n_err++; $display("FAIL rd0_addr: got %h expected 3", slot_address); end
      n_chk++; if (bus_data_rx !== 8'h5A) begin n_err++; $display("FAIL rd0_data: got %h expected 5a", bus_data_rx); end
      n_chk++; if (bus_wait !== 1'b0) begin n_err++; $display("FAIL rd0_wait: got %b expected 0", bus_wait); end
      n_chk++; if (bus_hit !== 1'b1) begin n_err++; $display("FAIL rd0_hit: got %b expected 1", bus_hit); end
      // Highest mapped slot.
      bus_address = 16'hFF3F;
      #1;
      n_chk++; if (slot_read !== 4'b1000) begin n_err++; $display("FAIL rd3_strobe: got %b expected 1000", slot_read); end
      n_chk++; if (bus_data_rx !== 8'hD3) begin n_err++; $display("FAIL rd3_data: got %h expected d3", bus_data_rx); end
      // Off-page: no strobes, no wait even if every slot stalls.
      bus_address = 16'h103F;
      slot_wait   = 4'hF;
      #1;
      n_chk++; if (bus_hit !== 1'b0) begin n_err++; $display("FAIL offpage_hit: got %b expected 0", bus_hit); end
      n_chk++; if (slot_read !== 4'b0000) begin n_err++; $display("FAIL offpage_strobe: got %b expected 0000", slot_read); end
      n_chk++; if (bus_wait !== 1'b0) begin n_err++; $display("FAIL offpage_wait: got %b expected 0", bus_wait); end
      slot_wait = 4'h0;
      nxt();
      idle();
   endtask

   task automatic test_wait_write();
      int waits;
      int strobes;
      waits   = 0;
      strobes = 0;
      nxt();
      bus_address = 16'hFF12;
      bus_data_tx = 8'h3C;
      bus_write   = 1'b1;
      slot_wait   = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (bus_wait === 1'b1) waits++;
         if (slot_write === 4'b0010) strobes++;
         nxt();
      end
      slot_wait = 4'b0000;
      #1;
      if (slot_write === 4'b0010) strobes++;
      n_chk++; if (bus_wait !== 1'b0) begin n_err++; $display("FAIL wwait_release: got %b expected 0", bus_wait); end
      n_chk++; if (slot_data_tx !== 8'h3C) begin n_err++; $display("FAIL wwait_txdata: got %h expected 3c", slot_data_tx); end
      n_chk++; if (waits !== 3) begin n_err++; $display("FAIL wwait_cycles: got %0d expected 3", waits); end
      n_chk++; if (strobes !== 4) begin n_err++; $display("FAIL wwait_strobe_held: got %0d expected 4", strobes); end
      nxt();
      idle();
      rd(16'hFFF0, rdat);
      n_chk++; if (rdat !== 8'h00) begin n_err++; $display("FAIL wwait_status: got %h expected 00", rdat); end
   endtask

   // Holds a stuck read on slot 2 and counts stall cycles until the abort cycle.
   task automatic count_to_abort(input string tag);
      int n;
      bit seen_end;
      n        = 0;
      seen_end = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus_wait === 1'b1) begin
            n++;
            nxt();
         end else begin
            seen_end = 1'b1;
            break;
         end
      end
      n_chk++; if (seen_end !== 1'b1) begin n_err++; $display("FAIL %s_bound: wait never released within 20 cycles", tag); end
      n_chk++; if (n !== TMO) begin n_err++; $display("FAIL %s_wait_cycles: got %0d expected %0d", tag, n, TMO); end
      n_chk++; if (bus_data_rx !== 8'hFF) begin n_err++; $display("FAIL %s_abort_data: got %h expected ff", tag, bus_data_rx); end
      n_chk++; if (slot_read !== 4'b0000) begin n_err++; $display("FAIL %s_abort_strobe: got %b expected 0000", tag, slot_read); end
      nxt();
      idle();
      slot_wait = 4'b0000;
   endtask

   task automatic test_timeout();
      nxt();
      bus_address = 16'hFF20;
      bus_read    = 1'b1;
      slot_wait   = 4'b0100;
      count_to_abort("tmo");
      rd(16'hFFF0, rdat);
      n_chk++; if (rdat !== 8'h01) begin n_err++; $display("FAIL tmo_status: got %h expected 01", rdat); end
      rd(16'hFFF1, rdat);
      n_chk++; if (rdat !== 8'h20) begin n_err++; $display("FAIL tmo_fault_addr: got %h expected 20", rdat); end
      rd(16'hFFF2, rdat);
      n_chk++; if (rdat !== 8'h00) begin n_err++; $display("FAIL tmo_fault_info: got %h expected 00", rdat); end
      wr(16'hFFF0, 8'h03);
      rd(16'hFFF0, rdat);
      n_chk++; if (rdat !== 8'h00) begin n_err++; $display("FAIL tmo_clear: got %h expected 00", rdat); end
   endtask

   task automatic test_unmapped();
      nxt();
      bus_address = 16'hFF70;
      bus_read    = 1'b1;
      #1;
      n_chk++; if (bus_data_rx !== 8'hFF) begin n_err++; $display("FAIL unm_data: got %h expected ff", bus_data_rx); end
      n_chk++; if (bus_wait !== 1'b0) begin n_err++; $display("FAIL unm_wait: got %b expected 0", bus_wait); end
      n_chk++; if (slot_read !== 4'b0000) begin n_err++; $display("FAIL unm_strobe: got %b expected 0000", slot_read); end
      nxt();
      idle();
      nxt();
      bus_address = 16'hFF80;
      bus_data_tx = 8'h55;
      bus_write   = 1'b1;
      #1;
      n_chk++; if (slot_write !== 4'b0000) begin n_err++; $display("FAIL unm_wstrobe: got %b expected 0000", slot_write); end
      nxt();
      idle();
      rd(16'hFFF0, rdat);
      n_chk++; if (rdat !== 8'h02) begin n_err++; $display("FAIL unm_status: got %h expected 02", rdat); end
      rd(16'hFFF1, rdat);
      n_chk++; if (rdat !== 8'h70) begin n_err++; $display("FAIL unm_fault_addr: got %h expected 70", rdat); end
      rd(16'hFFF2, rdat);
      n_chk++; if (rdat !== 8'h00) begin n_err++; $display("FAIL unm_fault_info: got %h expected 00", rdat); end
   endtask

   task automatic test_irq();
      #1;
      n_chk++; if (irq_error !== 1'b0) begin n_err++; $display("FAIL irq_disabled: got %b expected 0", irq_error); end
      nxt();
      bus_address = 16'hFFF3;
      bus_data_tx = 8'h01;
      bus_write   = 1'b1;
      nxt();
      idle();
      #1;
      n_chk++; if (irq_error !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b expected 0", irq_error); end
      nxt();
      #1;
      n_chk++; if (irq_error !== 1'b1) begin n_err++; $display("FAIL irq_assert: got %b expected 1", irq_error); end
      rd(16'hFFF3, rdat);
      n_chk++; if (rdat !== 8'h01) begin n_err++; $display("FAIL irq_ctrl_rd: got %h expected 01", rdat); end
      nxt();
      bus_address = 16'hFFF0;
      bus_data_tx = 8'h03;
      bus_write   = 1'b1;
      nxt();
      bus_write   = 1'b0;
      bus_read    = 1'b1;
      #1;
      n_chk++; if (bus_data_rx !== 8'h00) begin n_err++; $display("FAIL irq_status_cleared: got %h expected 00", bus_data_rx); end
      n_chk++; if (irq_error !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b expected 1", irq_error); end
      nxt();
      #1;
      n_chk++; if (irq_error !== 1'b0) begin n_err++; $display("FAIL irq_drop: got %b expected 0", irq_error); end
      idle();
   endtask

   task automatic test_reset_busy();
      nxt();
      bus_address = 16'hFF20;
      bus_read    = 1'b1;
      slot_wait   = 4'b0100;
      repeat (5) nxt();
      #1;
      n_chk++; if (dut.u_timeout.cnt !== 4'd5) begin n_err++; $display("FAIL rstbusy_cnt_pre: got %0d expected 5", dut.u_timeout.cnt); end
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      #1;
      n_chk++; if (dut.u_timeout.cnt !== 4'd0) begin n_err++; $display("FAIL rstbusy_cnt: got %0d expected 0", dut.u_timeout.cnt); end
      n_chk++; if (dut.u_timeout.state !== soc_regmap_pkg::ST_IDLE) begin n_err++; $display("FAIL rstbusy_state: got %0d expected 0", dut.u_timeout.state); end
      n_chk++; if (dut.status !== 2'b00) begin n_err++; $display("FAIL rstbusy_status: got %b expected 00", dut.status); end
      n_chk++; if (irq_error !== 1'b0) begin n_err++; $display("FAIL rstbusy_irq: got %b expected 0", irq_error); end
      count_to_abort("rstbusy");
      rd(16'hFFF0, rdat);
      n_chk++; if (rdat !== 8'h01) begin n_err++; $display("FAIL rstbusy_status_after: got %h expected 01", rdat); end
      #1;
      n_chk++; if (irq_error !== 1'b0) begin n_err++; $display("FAIL rstbusy_irq_masked: got %b expected 0", irq_error); end
   endtask

   initial begin
      n_chk        = 0;
      n_err        = 0;
      rst          = 1'b1;
      bus_address  = 16'h0000;
      bus_data_tx  = 8'h00;
      bus_read     = 1'b0;
      bus_write    = 1'b0;
      slot_data_rx = {8'hD3, 8'hC2, 8'hB1, 8'h5A};
      slot_wait    = 4'b0000;
      test_reset();
      test_slot_read();
      test_wait_write();
      test_timeout();
      test_unmapped();
      test_irq();
      test_reset_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
